// File: rtl/button_debouncer_pkg.sv
// Shared types and board timing constants for the button input path
// (synchronizer, debouncer, display control).
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_PEND    = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_PEND   = 2'd3
  } db_state_t;

  localparam int unsigned BOARD_CLK_HZ  = 100_000_000;
  localparam int unsigned DEBOUNCE_10MS = BOARD_CLK_HZ / 100;
  localparam int unsigned LONG_1S       = BOARD_CLK_HZ;

  function automatic logic is_high(input db_state_t s);
    return (s == HIGH_STABLE) || (s == HIGH_PEND);
  endfunction

  function automatic logic is_pend(input db_state_t s);
    return (s == LOW_PEND) || (s == HIGH_PEND);
  endfunction

endpackage

// File: rtl/button_debouncer_sat_counter.sv
// Up-counter with synchronous clear that stops at MAX instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign at_max = (count == MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_n)                count <= '0;
    else if (clear)            count <= '0;
    else if (enable && !at_max) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/button_debouncer.sv
// Stability-counter debouncer for one synchronized push-button: clean level,
// press/release strobes and a once-per-press long-hold strobe.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] FIRE_V = HW'(LONG_CYCLES - 1);

  db_state_t     state;
  logic          long_fired;
  logic [DW-1:0] db_cnt;
  logic          db_at_max;
  logic [HW-1:0] hold_cnt;
  logic          hold_at_max;

  logic differ, flip, fire;
  logic db_clear, db_en, hold_en;

  // A pending edge completes on the Nth consecutive differing sample, i.e.
  // when the counter already holds N-1 and the input still disagrees.
  assign differ   = (in != level);
  assign flip     = is_pend(state) && differ && db_at_max;
  assign db_clear = !differ || flip;
  assign db_en    = differ && !flip;
  assign hold_en  = is_high(state) && !hold_at_max;
  assign fire     = is_high(state) && (hold_cnt == FIRE_V) && !long_fired;

  sat_counter #(.WIDTH(DW), .MAX(DEBOUNCE_CYCLES - 1)) u_db_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (db_clear),
    .enable (db_en),
    .count  (db_cnt),
    .at_max (db_at_max)
  );

  // Hold time survives bounce inside HIGH_PEND; only a completed edge clears it.
  sat_counter #(.WIDTH(HW), .MAX(LONG_CYCLES)) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flip),
    .enable (hold_en),
    .count  (hold_cnt),
    .at_max (hold_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOW_STABLE;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_pulse <= 1'b0;
      long_fired <= 1'b0;
    end else begin
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_pulse <= fire;
      case (state)
        LOW_STABLE:  if (differ) state <= LOW_PEND;
        LOW_PEND: begin
          if (!differ) state <= LOW_STABLE;
          else if (db_at_max) begin
            state <= HIGH_STABLE;
            level <= 1'b1;
            rise  <= 1'b1;
          end
        end
        HIGH_STABLE: if (differ) state <= HIGH_PEND;
        HIGH_PEND: begin
          if (!differ) state <= HIGH_STABLE;
          else if (db_at_max) begin
            state <= LOW_STABLE;
            level <= 1'b0;
            fall  <= 1'b1;
          end
        end
        default: state <= LOW_STABLE;
      endcase
      // Release re-arms the long strobe even if it fires on the same edge.
      if (flip && level) long_fired <= 1'b0;
      else if (fire)     long_fired <= 1'b1;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: driver pushes per-cycle expectations from a sample-history
// model; a negedge monitor pops and compares against the DUT outputs.
module tb_button_debouncer;

  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic long_pulse;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_s;
  logic level, rise, fall, long_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int long_seen = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // reference model state
  logic m_level = 1'b0;
  int   m_age   = 0;
  logic m_fired = 1'b0;
  logic hist[$];

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_s),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .long_pulse (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // The level flips once the last D samples all disagree with it; the long
  // strobe is due when the level has been high for L edges since the press.
  task automatic model_edge(input logic i, input logic r);
    exp_t e;
    logic prev, all_diff;
    e = '0;
    if (!r) begin
      hist.delete();
      m_level = 1'b0;
      m_age   = 0;
      m_fired = 1'b0;
    end else begin
      prev = m_level;
      hist.push_back(i);
      if (hist.size() > D) void'(hist.pop_front());
      if (prev) begin
        if (m_age < L) m_age++;
        if (m_age == L && !m_fired) begin
          e.long_pulse = 1'b1;
          m_fired = 1'b1;
        end
      end
      all_diff = (hist.size() == D);
      foreach (hist[k]) if (hist[k] == prev) all_diff = 1'b0;
      if (all_diff) begin
        m_level = !prev;
        m_age   = 0;
        if (m_level) e.rise = 1'b1;
        else begin
          e.fall  = 1'b1;
          m_fired = 1'b0;
        end
      end
    end
    e.level = m_level;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic i, input logic r);
    in_s  = i;
    rst_n = r;
    @(posedge clk);
    model_edge(i, r);
    #1;
  endtask

  task automatic run(input logic v, input int n);
    for (int k = 0; k < n; k++) step(v, 1'b1);
  endtask

  task automatic drain;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("level",      level,      mon_e.level);
      check("rise",       rise,       mon_e.rise);
      check("fall",       fall,       mon_e.fall);
      check("long_pulse", long_pulse, mon_e.long_pulse);
      if (long_pulse === 1'b1) long_seen++;
    end
  end

  initial begin
    rst_n = 1'b0;
    in_s  = 1'b1;

    // reset with input high, then release: rise after 4 samples
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    run(1'b1, 8);
    run(1'b0, 8);

    // bounce never settles
    begin
      logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      foreach (pat[k]) step(pat[k], 1'b1);
    end
    run(1'b0, 4);

    // clean press/release
    drain();
    long_seen = 0;
    run(1'b1, 20);
    run(1'b0, 8);
    drain();
    n_checks++;
    if (long_seen != 1) begin
      n_fail++;
      $display("FAIL clean_long_count: got %0d expected 1", long_seen);
    end

    // long press with a 2-cycle glitch
    long_seen = 0;
    run(1'b1, 25);
    run(1'b0, 2);
    run(1'b1, 13);
    run(1'b0, 8);
    drain();
    n_checks++;
    if (long_seen != 1) begin
      n_fail++;
      $display("FAIL glitch_long_count: got %0d expected 1", long_seen);
    end

    // reset mid-pending abandons the count
    run(1'b1, 3);
    step(1'b1, 1'b0);
    run(1'b1, 6);
    run(1'b0, 8);

    // boundary: 3 highs no rise, 4 highs rise
    run(1'b1, 3);
    run(1'b0, 6);
    run(1'b1, 4);
    run(1'b0, 8);

    // randomized runs with occasional resets
    for (int k = 0; k < 120; k++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) step(v, 1'b0);
      else run(v, $urandom_range(1, 14));
    end
    run(1'b0, 8);

    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
